mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 29 ++
 rtl/mem_arbiter_rr_arb2.sv | 12 +
 rtl/mem_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-port memory arbiter: command codes, FSM states, MMIO map.
package mem_arb_pkg;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_ACC  = 2'd1;
  localparam state_t S_RESP = 2'd2;

  localparam logic [8:0] MMIO_LED_ADDR = 9'h100;
  localparam logic [8:0] MMIO_SW_ADDR  = 9'h140;

  // Code 2'b11 is reserved and treated like NONE.
  function automatic logic cmd_valid(input logic req, input logic [1:0] cmd);
    return req && (cmd != MNONE) && (cmd != 2'b11);
  endfunction

  function automatic logic is_led_addr(input logic [8:0] addr);
    return addr == MMIO_LED_ADDR;
  endfunction

  function automatic logic is_sw_addr(input logic [8:0] addr);
    return addr == MMIO_SW_ADDR;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker, purely combinational: on a tie the side that did not win last time wins.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_winner,
  output logic       any,
  output logic       winner
);

  assign any    = |valid;
  assign winner = (&valid) ? ~last_winner : valid[1];

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester single-port RAM arbiter: gnt 1 cycle and rvalid 2 cycles after the request is sampled in IDLE.
// Requests are held by the requester until gnt; MEM_ARBITER_MMIO_EN maps addr[8]=1 to the LED/switch registers.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        r0_req,
  input  logic [1:0]  r0_cmd,
  input  logic [8:0]  r0_addr,
  input  logic [15:0] r0_wdata,
  input  logic        r1_req,
  input  logic [1:0]  r1_cmd,
  input  logic [8:0]  r1_addr,
  input  logic [15:0] r1_wdata,
  output logic        r0_gnt,
  output logic        r1_gnt,
  output logic        r0_rvalid,
  output logic        r1_rvalid,
  output logic [15:0] rdata,
  output logic [8:0]  ram_addr,
  output logic        ram_re,
  output logic        ram_we,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  input  logic [7:0]  sw,
  output logic [7:0]  led
);

  state_t      state_q, state_d;
  logic        win_q, win_d;
  logic        last_q, last_d;
  logic [1:0]  cmd_q, cmd_d;
  logic [8:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [7:0]  led_q, led_d;

  logic [1:0]  vld;
  logic        any;
  logic        winner;

  assign vld = {cmd_valid(r1_req, r1_cmd), cmd_valid(r0_req, r0_cmd)};

  rr_arb2 u_rr (
    .valid       (vld),
    .last_winner (last_q),
    .any         (any),
    .winner      (winner)
  );

  logic        is_mmio;
  logic [15:0] mmio_rdata;
`ifdef MEM_ARBITER_MMIO_EN
  assign is_mmio    = addr_q[8];
  assign mmio_rdata = is_sw_addr(addr_q) ? {8'h00, sw} : 16'h0000;
`else
  logic unused_sw;
  assign is_mmio    = 1'b0;
  assign mmio_rdata = 16'h0000;
  assign unused_sw  = ^sw;
`endif

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    led_d   = led_q;
    case (state_q)
      S_IDLE: begin
        if (any) begin
          win_d   = winner;
          last_d  = winner;
          cmd_d   = winner ? r1_cmd   : r0_cmd;
          addr_d  = winner ? r1_addr  : r0_addr;
          wdata_d = winner ? r1_wdata : r0_wdata;
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        state_d = (cmd_q == MREAD) ? S_RESP : S_IDLE;
`ifdef MEM_ARBITER_MMIO_EN
        if (cmd_q == MWRITE && is_led_addr(addr_q)) led_d = wdata_q[7:0];
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      win_q   <= 1'b0;
      last_q  <= 1'b1;
      cmd_q   <= MNONE;
      addr_q  <= '0;
      wdata_q <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      led_q   <= led_d;
    end
  end

  // Strobes are masked while reset is high so an aborted access never surfaces.
  logic acc, resp;
  assign acc  = (state_q == S_ACC)  && !reset;
  assign resp = (state_q == S_RESP) && !reset;

  assign r0_gnt    = acc && !win_q;
  assign r1_gnt    = acc &&  win_q;
  assign ram_addr  = addr_q;
  assign ram_re    = acc && (cmd_q == MREAD)  && !is_mmio;
  assign ram_we    = acc && (cmd_q == MWRITE) && !is_mmio;
  assign ram_wdata = wdata_q;
  assign r0_rvalid = resp && !win_q;
  assign r1_rvalid = resp &&  win_q;
  assign rdata     = resp ? (is_mmio ? mmio_rdata : ram_rdata) : 16'h0000;
  assign led       = led_q;

endmodule
